mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage load/store engine that consumes the EX/MEM pipeline register outputs, performs byte/halfword/word accesses on a req/ack data bus, and drives registered results toward write-back. It stalls upstream pipeline stages while a bus access is outstanding. Non-memory instructions pass through with one cycle of latency.

## Interface
- REG_ADDR_W, default 5: destination register address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_wd  in  REG_ADDR_W  destination register from EX/MEM.
- ex_wreg  in  1  register write enable from EX/MEM.
- ex_wdata  in  32  ALU result from EX/MEM.
- mem_op  in  4  operation code:
  - 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW.
  - 9..15 are treated as NONE.
- mem_addr  in  32  byte address.
- mem_sdata  in  32  store data; the low byte or halfword is used for SB/SH.
- bus_req  out  1  access request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address; bits [1:0] are forced to 0.
- bus_sel  out  4  byte lanes.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  access complete; bus_rdata is valid in the same cycle.
- bus_rdata  in  32  read data.
- stall_req  out  1  combinational; upstream holds all inputs while this is 1.
- out_wd  out  REG_ADDR_W  registered write-back register address.
- out_wreg  out  1  registered write-back enable.
- out_wdata  out  32  registered write-back data.
- excp_misalign  out  1  registered one-cycle pulse for a misaligned access.

## Operation
- States: IDLE, BUSY.
- Reset:
  - state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0.
  - out_wd=0, out_wreg=0, out_wdata=0, excp_misalign=0.
  - Reset wins over every other event. Asserting reset while in BUSY abandons the access and drops bus_req at that edge.
- Byte order is big-endian:
  - addr[1:0]=0 selects lane sel=1000, data[31:24].
  - addr[1:0]=3 selects sel=0001, data[7:0].
  - A halfword at addr[1]=0 uses sel=1100, data[31:16]; at addr[1]=1 it uses sel=0011, data[15:0].
  - A word uses sel=1111.
- Alignment:
  - LH, LHU and SH require addr[0]=0.
  - LW and SW require addr[1:0]=0.
  - Byte operations are always aligned.
- IDLE, op NONE: at the next edge, out_* <= ex_*; stall_req=0.
- IDLE, misaligned memory op:
  - No bus access; stall_req=0.
  - At the next edge: excp_misalign<=1, out_wreg<=0, out_wd<=ex_wd, out_wdata<=0.
- IDLE, aligned memory op:
  - stall_req=1 in this cycle.
  - At the next edge: bus_req<=1; bus_we/addr/sel/wdata are loaded; state<=BUSY.
  - out_wreg<=0 (bubble).
- BUSY:
  - bus_* are held stable until the cycle in which bus_ack=1.
  - stall_req = !bus_ack.
  - Each non-ack cycle loads out_wreg<=0.
- BUSY, bus_ack=1 (ack edge):
  - state<=IDLE; bus_req<=0; bus_we<=0.
  - Load result: out_wreg<=ex_wreg, out_wd<=ex_wd, out_wdata<=extended lane data.
    - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word.
  - Store result: out_wreg<=0, out_wdata<=0.
- bus_wdata replication:
  - SB puts the byte in all 4 lanes.
  - SH puts the halfword in both halves.
  - SW puts the word as-is.
- bus_ack sampled while in IDLE is ignored.
- excp_misalign is 0 on every edge except those defined above.

## Timing
- Non-memory op: result appears 1 cycle after the op is presented.
- Memory op with ack N cycles after bus_req rises (N≥0, where N=0 means ack in the first BUSY cycle):
  - The op occupies the inputs for N+2 cycles.
  - stall_req is high for N+1 cycles.
  - The result is registered at the ack edge.
- The upstream pipeline advances on the same edge as the ack. The next op is sampled in IDLE with no idle gap.
- Back-to-back memory ops: the new op's stall_req rises combinationally in the first IDLE cycle. bus_req therefore drops for exactly one cycle between accesses.
- No duplicate write-back: out_wreg is 1 for exactly one cycle per load or register-writing non-memory op.

## Test plan
- Reset: hold rst for 2 cycles during BUSY → bus_req=0 and all out_*=0 on the next edge; state is IDLE and stall_req=0.
- Passthrough: ex_wd=5, ex_wreg=1, ex_wdata=0xDEADBEEF, mem_op=0 → next cycle out_wd=5, out_wreg=1, out_wdata=0xDEADBEEF; stall_req stays 0.
- Loads, bus_rdata=0x80F1_7F02, ack with N=2:
  - LB addr=0x100 → out_wdata=0xFFFFFF80.
  - LBU addr=0x103 → 0x00000002.
  - LH addr=0x102 → 0x00007F02.
  - LW → 0x80F17F02.
  - For each: bus_addr=0x100, stall_req high for 3 cycles, and out_wreg=1 for exactly 1 cycle.
- Stores:
  - SB mem_sdata=0x12345678 addr=0x201 → bus_sel=0100, bus_wdata=0x78787878, bus_we=1, bus_addr=0x200.
  - SH addr=0x202 → bus_sel=0011, bus_wdata=0x56785678.
  - For both: out_wreg stays 0.
- Misaligned: LW addr=0x102 → no bus_req, stall_req=0, one-cycle excp_misalign=1, out_wreg=0. Repeat with SH addr=0x1 → same response.
- Back-to-back: LW then SW with zero-wait ack (N=0):
  - Each access is held for 2 cycles.
  - bus_req sequence is 1,0,1.
  - Exactly one out_wreg pulse (from the LW).

Source files
------------

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
// Data-bus bundle between the MEM-stage load/store engine and memory.
//   req   : access request (master -> slave)
//   we    : 1 = write (master -> slave)
//   addr  : word address, bits [1:0] always 0 (master -> slave)
//   sel   : byte lanes, big-endian lane order (master -> slave)
//   wdata : lane-replicated store data (master -> slave)
//   ack   : access complete, rdata valid in the same cycle (slave -> master)
//   rdata : read data (slave -> master)
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM-stage load/store engine. Consumes EX/MEM register outputs, performs
// byte/halfword/word accesses over a req/ack bus and registers results for
// write-back. Holds upstream via stall_req_o while an access is outstanding;
// non-memory ops pass through with one cycle of latency.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ex_wd_i           : destination register from EX/MEM
//   ex_wreg_i         : register write enable from EX/MEM
//   ex_wdata_i        : ALU result from EX/MEM
//   mem_op_i          : 0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW (9..15 NONE)
//   mem_addr_i        : byte address
//   mem_sdata_i       : store data
//   bus               : data bus (master side)
//   stall_req_o       : combinational stall toward upstream stages
//   out_wd_o          : registered write-back register address
//   out_wreg_o        : registered write-back enable
//   out_wdata_o       : registered write-back data
//   excp_misalign_o   : registered one-cycle misaligned-access pulse
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_wreg_i,
  input  logic [31:0]           ex_wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_sdata_i,
  mem_access_stage_if.master    bus,
  output logic                  stall_req_o,
  output logic [REG_ADDR_W-1:0] out_wd_o,
  output logic                  out_wreg_o,
  output logic [31:0]           out_wdata_o,
  output logic                  excp_misalign_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [31:0]           bus_addr_q, bus_addr_d;
  logic [3:0]            bus_sel_q, bus_sel_d;
  logic [31:0]           bus_wdata_q, bus_wdata_d;
  logic [REG_ADDR_W-1:0] out_wd_q, out_wd_d;
  logic                  out_wreg_q, out_wreg_d;
  logic [31:0]           out_wdata_q, out_wdata_d;
  logic                  excp_q, excp_d;
  // Op and byte offset of the outstanding access, used to extract load data.
  logic [3:0]            op_q, op_d;
  logic [1:0]            lane_q, lane_d;

  // Decoded view of the op currently presented on the inputs.
  logic        is_load, is_store, misalign;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic [31:0] load_data;
  logic        stall;

  // Big-endian lane view of the read data: lane 0 is the most significant byte.
  logic [7:0] lane_byte [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_byte[gi] = bus.rdata[31-8*gi -: 8];
  end

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    misalign  = 1'b0;
    req_sel   = 4'b0000;
    req_wdata = 32'h0;
    case (mem_op_i)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        req_sel = 4'b1000 >> mem_addr_i[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load  = 1'b1;
        misalign = mem_addr_i[0];
        req_sel  = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      end
      OP_LW: begin
        is_load  = 1'b1;
        misalign = |mem_addr_i[1:0];
        req_sel  = 4'b1111;
      end
      OP_SB: begin
        is_store  = 1'b1;
        req_sel   = 4'b1000 >> mem_addr_i[1:0];
        req_wdata = {4{mem_sdata_i[7:0]}};
      end
      OP_SH: begin
        is_store  = 1'b1;
        misalign  = mem_addr_i[0];
        req_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        req_wdata = {2{mem_sdata_i[15:0]}};
      end
      OP_SW: begin
        is_store  = 1'b1;
        misalign  = |mem_addr_i[1:0];
        req_sel   = 4'b1111;
        req_wdata = mem_sdata_i;
      end
      default: ;
    endcase
  end

  // Load result extraction using the op/offset captured when the access started.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = lane_byte[lane_q];
    h = lane_q[1] ? bus.rdata[15:0] : bus.rdata[31:16];
    case (op_q)
      OP_LB:   load_data = {{24{b[7]}}, b};
      OP_LBU:  load_data = {24'h0, b};
      OP_LH:   load_data = {{16{h[15]}}, h};
      OP_LHU:  load_data = {16'h0, h};
      default: load_data = bus.rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    out_wd_d    = out_wd_q;
    out_wreg_d  = out_wreg_q;
    out_wdata_d = out_wdata_q;
    excp_d      = 1'b0;
    op_d        = op_q;
    lane_d      = lane_q;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!is_load && !is_store) begin
          out_wd_d    = ex_wd_i;
          out_wreg_d  = ex_wreg_i;
          out_wdata_d = ex_wdata_i;
        end else if (misalign) begin
          // Faulting access never reaches the bus; upstream is not stalled.
          excp_d      = 1'b1;
          out_wreg_d  = 1'b0;
          out_wd_d    = ex_wd_i;
          out_wdata_d = 32'h0;
        end else begin
          stall       = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = {mem_addr_i[31:2], 2'b00};
          bus_sel_d   = req_sel;
          bus_wdata_d = req_wdata;
          op_d        = mem_op_i;
          lane_d      = mem_addr_i[1:0];
          out_wreg_d  = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (bus.ack) begin
          // Upstream advances on this same edge, so the next op is seen in IDLE
          // immediately afterward.
          state_d   = IDLE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          out_wd_d  = ex_wd_i;
          if (bus_we_q) begin
            out_wreg_d  = 1'b0;
            out_wdata_d = 32'h0;
          end else begin
            out_wreg_d  = ex_wreg_i;
            out_wdata_d = load_data;
          end
        end else begin
          stall      = 1'b1;
          out_wreg_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_sel_q   <= 4'h0;
      bus_wdata_q <= 32'h0;
      out_wd_q    <= '0;
      out_wreg_q  <= 1'b0;
      out_wdata_q <= 32'h0;
      excp_q      <= 1'b0;
      op_q        <= 4'h0;
      lane_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      out_wd_q    <= out_wd_d;
      out_wreg_q  <= out_wreg_d;
      out_wdata_q <= out_wdata_d;
      excp_q      <= excp_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
    end
  end

  assign bus.req         = bus_req_q;
  assign bus.we          = bus_we_q;
  assign bus.addr        = bus_addr_q;
  assign bus.sel         = bus_sel_q;
  assign bus.wdata       = bus_wdata_q;
  assign stall_req_o     = stall;
  assign out_wd_o        = out_wd_q;
  assign out_wreg_o      = out_wreg_q;
  assign out_wdata_o     = out_wdata_q;
  assign excp_misalign_o = excp_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for mem_access_stage. Expected write-backs are queued when
// an op is driven and popped by a monitor whenever out_wreg_o is seen.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        stall_req;
  logic [4:0]  out_wd;
  logic        out_wreg;
  logic [31:0] out_wdata;
  logic        excp_misalign;

  int checks    = 0;
  int failures  = 0;
  int pushed    = 0;
  int wb_pulses = 0;
  wb_t sb_q[$];

  mem_access_stage_if bus_if();

  mem_access_stage #(.REG_ADDR_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_wd_i         (ex_wd),
    .ex_wreg_i       (ex_wreg),
    .ex_wdata_i      (ex_wdata),
    .mem_op_i        (mem_op),
    .mem_addr_i      (mem_addr),
    .mem_sdata_i     (mem_sdata),
    .bus             (bus_if),
    .stall_req_o     (stall_req),
    .out_wd_o        (out_wd),
    .out_wreg_o      (out_wreg),
    .out_wdata_o     (out_wdata),
    .excp_misalign_o (excp_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-back monitor: every out_wreg pulse must match the oldest queued entry.
  always @(negedge clk) begin
    if (!rst && out_wreg === 1'b1) begin
      wb_pulses++;
      chk("wb_expected", {31'h0, sb_q.size() != 0}, 32'h1);
      if (sb_q.size() != 0) begin
        wb_t e;
        e = sb_q.pop_front();
        chk("wb_wd", {27'h0, out_wd}, {27'h0, e.wd});
        chk("wb_wdata", out_wdata, e.data);
      end
    end
  end

  task automatic set_idle(input logic [4:0] wd, input logic [31:0] wdata);
    mem_op = 4'd0; mem_addr = 32'h0; mem_sdata = 32'h0;
    ex_wd = wd; ex_wreg = 1'b0; ex_wdata = wdata;
  endtask

  // Drives one memory op, acks it n cycles after bus_req rises, and checks the
  // bus fields every busy cycle. Returns 1 time unit after the ack edge.
  task automatic do_mem(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] rdata, input int n, input logic [3:0] exp_sel,
                        input logic [31:0] exp_wdata, input logic is_load,
                        input logic [31:0] exp_result);
    int stall_cnt;
    stall_cnt = 0;
    mem_op = op; mem_addr = addr; mem_sdata = sdata;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = 32'h5555_AAAA;
    if (is_load && wreg) begin
      sb_q.push_back('{wd, exp_result});
      pushed++;
    end
    @(negedge clk);
    chk({tag, "_req_idle"}, {31'h0, bus_if.req}, 32'h0);
    stall_cnt += int'(stall_req);
    for (int c = 0; c <= n; c++) begin
      @(posedge clk); #1;
      bus_if.ack   = (c == n);
      bus_if.rdata = (c == n) ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      chk({tag, "_req"}, {31'h0, bus_if.req}, 32'h1);
      chk({tag, "_addr"}, bus_if.addr, {addr[31:2], 2'b00});
      chk({tag, "_sel"}, {28'h0, bus_if.sel}, {28'h0, exp_sel});
      chk({tag, "_we"}, {31'h0, bus_if.we}, {31'h0, !is_load});
      if (!is_load) chk({tag, "_wdata"}, bus_if.wdata, exp_wdata);
      stall_cnt += int'(stall_req);
    end
    @(posedge clk); #1;
    bus_if.ack   = 1'b0;
    bus_if.rdata = 32'h0BAD_0BAD;
    chk({tag, "_stall_cycles"}, stall_cnt, n + 1);
  endtask

  task automatic check_misalign(input string tag, input logic [3:0] op, input logic [31:0] addr);
    mem_op = op; mem_addr = addr; mem_sdata = 32'hFFFF_FFFF;
    ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h1111_2222;
    @(negedge clk);
    chk({tag, "_stall"}, {31'h0, stall_req}, 32'h0);
    @(posedge clk); #1;
    set_idle(5'd0, 32'h0);
    @(negedge clk);
    chk({tag, "_excp"}, {31'h0, excp_misalign}, 32'h1);
    chk({tag, "_wreg"}, {31'h0, out_wreg}, 32'h0);
    chk({tag, "_wd"}, {27'h0, out_wd}, 32'd7);
    chk({tag, "_wdata"}, out_wdata, 32'h0);
    chk({tag, "_req"}, {31'h0, bus_if.req}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_excp_pulse"}, {31'h0, excp_misalign}, 32'h0);
    chk({tag, "_req2"}, {31'h0, bus_if.req}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_idle(5'd0, 32'h0);
    bus_if.ack = 1'b0;
    bus_if.rdata = 32'h0BAD_0BAD;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'h0, bus_if.req}, 32'h0);
    chk("rst_we", {31'h0, bus_if.we}, 32'h0);
    chk("rst_addr", bus_if.addr, 32'h0);
    chk("rst_sel", {28'h0, bus_if.sel}, 32'h0);
    chk("rst_bwdata", bus_if.wdata, 32'h0);
    chk("rst_out_wd", {27'h0, out_wd}, 32'h0);
    chk("rst_out_wreg", {31'h0, out_wreg}, 32'h0);
    chk("rst_out_wdata", out_wdata, 32'h0);
    chk("rst_excp", {31'h0, excp_misalign}, 32'h0);
    chk("rst_stall", {31'h0, stall_req}, 32'h0);
    @(posedge clk); #1;

    // Passthrough, one cycle latency
    mem_op = 4'd0; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
    sb_q.push_back('{5'd5, 32'hDEADBEEF}); pushed++;
    @(negedge clk);
    chk("pass_stall", {31'h0, stall_req}, 32'h0);
    @(posedge clk); #1;
    // Ops 9..15 behave as NONE
    mem_op = 4'd12; mem_addr = 32'h3; ex_wd = 5'd6; ex_wreg = 1'b1; ex_wdata = 32'h0000_00C6;
    sb_q.push_back('{5'd6, 32'h0000_00C6}); pushed++;
    @(negedge clk);
    chk("op12_stall", {31'h0, stall_req}, 32'h0);
    @(posedge clk); #1;
    set_idle(5'd0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;

    // Loads with ack two cycles after bus_req rises
    do_mem("lb",  4'd1, 32'h100, 32'h0, 5'd1, 1'b1, 32'h80F17F02, 2, 4'b1000, 32'h0, 1'b1, 32'hFFFFFF80);
    set_idle(5'd0, 32'h0);
    @(negedge clk); @(posedge clk); #1;
    do_mem("lbu", 4'd2, 32'h103, 32'h0, 5'd2, 1'b1, 32'h80F17F02, 2, 4'b0001, 32'h0, 1'b1, 32'h00000002);
    set_idle(5'd0, 32'h0);
    @(negedge clk); @(posedge clk); #1;
    do_mem("lh",  4'd3, 32'h102, 32'h0, 5'd3, 1'b1, 32'h80F17F02, 2, 4'b0011, 32'h0, 1'b1, 32'h00007F02);
    set_idle(5'd0, 32'h0);
    @(negedge clk); @(posedge clk); #1;
    do_mem("lhu", 4'd4, 32'h100, 32'h0, 5'd4, 1'b1, 32'h80F17F02, 1, 4'b1100, 32'h0, 1'b1, 32'h000080F1);
    set_idle(5'd0, 32'h0);
    @(negedge clk); @(posedge clk); #1;
    do_mem("lw",  4'd5, 32'h100, 32'h0, 5'd8, 1'b1, 32'h80F17F02, 2, 4'b1111, 32'h0, 1'b1, 32'h80F17F02);
    set_idle(5'd0, 32'h0);
    @(negedge clk);
    chk("post_load_req", {31'h0, bus_if.req}, 32'h0);
    chk("post_load_stall", {31'h0, stall_req}, 32'h0);
    @(posedge clk); #1;

    // Stores with ex_wreg set: write-back must stay suppressed
    do_mem("sb", 4'd6, 32'h201, 32'h12345678, 5'd9, 1'b1, 32'h0, 2, 4'b0100, 32'h78787878, 1'b0, 32'h0);
    set_idle(5'd0, 32'h0);
    @(negedge clk);
    chk("sb_out_wreg", {31'h0, out_wreg}, 32'h0);
    @(posedge clk); #1;
    do_mem("sh", 4'd7, 32'h202, 32'h12345678, 5'd10, 1'b1, 32'h0, 2, 4'b0011, 32'h56785678, 1'b0, 32'h0);
    set_idle(5'd0, 32'h0);
    @(negedge clk);
    chk("sh_out_wreg", {31'h0, out_wreg}, 32'h0);
    chk("sh_out_wdata", out_wdata, 32'h0);
    @(posedge clk); #1;

    // Misaligned accesses
    check_misalign("mis_lw", 4'd5, 32'h102);
    check_misalign("mis_sh", 4'd7, 32'h001);

    // Back-to-back LW then SW, zero-wait ack
    do_mem("b2b_lw", 4'd5, 32'h100, 32'h0, 5'd11, 1'b1, 32'hA5A5_0F0F, 0, 4'b1111, 32'h0, 1'b1, 32'hA5A5_0F0F);
    do_mem("b2b_sw", 4'd8, 32'h104, 32'hCAFEBABE, 5'd12, 1'b1, 32'h0, 0, 4'b1111, 32'hCAFEBABE, 1'b0, 32'h0);
    set_idle(5'd0, 32'h0);
    @(negedge clk);
    chk("b2b_req_end", {31'h0, bus_if.req}, 32'h0);
    @(posedge clk); #1;

    // Reset during BUSY: first leave non-zero out_* behind
    set_idle(5'd3, 32'h0000_1234);
    @(posedge clk); #1;
    mem_op = 4'd5; mem_addr = 32'h100; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h0000_1234;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rbusy_req", {31'h0, bus_if.req}, 32'h1);
    chk("rbusy_out_wd", {27'h0, out_wd}, 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    set_idle(5'd0, 32'h0);
    @(posedge clk); #1;
    chk("rbusy_req_drop", {31'h0, bus_if.req}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rbusy_req_after", {31'h0, bus_if.req}, 32'h0);
    chk("rbusy_out_wd0", {27'h0, out_wd}, 32'h0);
    chk("rbusy_out_wreg0", {31'h0, out_wreg}, 32'h0);
    chk("rbusy_out_wdata0", out_wdata, 32'h0);
    chk("rbusy_stall", {31'h0, stall_req}, 32'h0);
    // An ack in IDLE must be ignored
    @(posedge clk); #1;
    bus_if.ack = 1'b1;
    @(posedge clk); #1;
    bus_if.ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_req", {31'h0, bus_if.req}, 32'h0);
    chk("idle_ack_wreg", {31'h0, out_wreg}, 32'h0);
    @(posedge clk); #1;

    chk("wb_count", wb_pulses, pushed);
    chk("sb_empty", sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
